// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI slave receiver.
package spi_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_e;

   localparam int SPI_DATA_WIDTH  = 8;
   localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous input, followed by a history
// flop so the caller gets single-cycle rise/fall strobes on the clean level.
module spi_input_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;

   // Synchronizer chain and history flop, cleared by the asynchronous reset.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver, MSB first, oversampled by clk.
// Optional full-duplex return path on MISO is compiled in when the macro
// SPI_SLAVE_MISO_EN is defined; otherwise miso is tied low and tx_data ignored.
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
   parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  ss_n,
   output logic                  miso,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy
);

   localparam int                CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   // Synchronized pin views
   logic sclk_level, sclk_rise, sclk_fall;
   logic mosi_s,     mosi_rise, mosi_fall;
   logic ss_s,       ss_rise,   ss_fall;

   spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk   (clk),
      .reset (reset),
      .din   (sclk),
      .level (sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   // Same depth as sclk so the data bit lines up with its sampling edge.
   spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk   (clk),
      .reset (reset),
      .din   (mosi),
      .level (mosi_s),
      .rise  (mosi_rise),
      .fall  (mosi_fall)
   );

   spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
      .clk   (clk),
      .reset (reset),
      .din   (ss_n),
      .level (ss_s),
      .rise  (ss_rise),
      .fall  (ss_fall)
   );

   // Synchronizer outputs this block has no use for.
   logic unused_sync;
   assign unused_sync = ^{sclk_level, sclk_fall, mosi_rise, mosi_fall, ss_rise, ss_fall};

   // Receive state
   spi_state_e            state, state_next;
   logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
   logic [DATA_WIDTH-1:0] rx_shift, rx_shift_next;
   logic [DATA_WIDTH-1:0] rx_data_next;
   logic                  rx_valid_next;
   logic                  word_done;

   // Next-state and receive datapath; a deasserted ss_n outranks a same-cycle rise.
   // NOTE: every output of this block gets a default first, so no path leaves a latch.
   always_comb begin
      state_next    = state;
      bit_cnt_next  = bit_cnt;
      rx_shift_next = rx_shift;
      rx_data_next  = rx_data;
      rx_valid_next = 1'b0;
      word_done     = 1'b0;
      case (state)
         IDLE: begin
            if (!ss_s) begin
               bit_cnt_next  = '0;
               rx_shift_next = '0;
               state_next    = SHIFT;
            end
         end
         SHIFT: begin
            if (ss_s) begin
               // Partial word is dropped; rx_data keeps its last complete value.
               state_next = IDLE;
            end else if (sclk_rise) begin
               rx_shift_next = {rx_shift[DATA_WIDTH-2:0], mosi_s};
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt_next  = '0;
                  rx_data_next  = rx_shift_next;
                  rx_valid_next = 1'b1;
                  word_done     = 1'b1;
               end else begin
                  bit_cnt_next = bit_cnt + CNT_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and receive registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         state    <= state_next;
         bit_cnt  <= bit_cnt_next;
         rx_shift <= rx_shift_next;
         rx_data  <= rx_data_next;
         rx_valid <= rx_valid_next;
      end
   end

   assign busy = (state == SHIFT);

`ifdef SPI_SLAVE_MISO_EN
   logic [DATA_WIDTH-1:0] tx_shift;
   logic                  reload;

   // Transmit shifter: loaded at frame start, advanced on SCLK falls, and
   // reloaded from tx_data on the first fall after each completed word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_shift <= '0;
         reload   <= 1'b0;
      end else if (state == IDLE) begin
         if (!ss_s) begin
            tx_shift <= tx_data;
            reload   <= 1'b0;
         end
      end else if (!ss_s) begin
         if (word_done) begin
            reload <= 1'b1;
         end else if (sclk_fall) begin
            if (reload) begin
               tx_shift <= tx_data;
               reload   <= 1'b0;
            end else begin
               tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   assign miso = busy & tx_shift[DATA_WIDTH-1];
`else
   // Transmit path absent: miso held low and tx_data unused.
   logic unused_tx;
   assign unused_tx = ^{tx_data, word_done};
   assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: table-driven single-word frames,
// hand-written multi-word / abort / reset sequences, and random multi-word
// frames compared against a word-level model of the link.
module tb_spi_slave_rx;

   localparam int W = 8;
`ifdef SPI_SLAVE_MISO_EN
   localparam bit MISO_EN = 1'b1;
`else
   localparam bit MISO_EN = 1'b0;
`endif

   logic         clk     = 1'b0;
   logic         reset   = 1'b1;
   logic         sclk    = 1'b0;
   logic         mosi    = 1'b0;
   logic         ss_n    = 1'b1;
   logic [W-1:0] tx_data = '0;
   logic         miso;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         busy;

   always #5 clk = ~clk;

   spi_slave_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .sclk     (sclk),
      .mosi     (mosi),
      .ss_n     (ss_n),
      .miso     (miso),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: counts valid pulses, logs delivered words, flags protocol breaks.
   int           valid_cnt  = 0;
   int           consec_err = 0;
   int           idle_err   = 0;
   logic         prev_valid = 1'b0;
   logic [W-1:0] rx_log[$];

   always @(posedge clk) begin
      #1;
      if (rx_valid === 1'b1) begin
         valid_cnt++;
         rx_log.push_back(rx_data);
         if (prev_valid) consec_err++;
         if (busy !== 1'b1) idle_err++;
      end
      prev_valid = (rx_valid === 1'b1);
   end

   initial begin
      #(1_000_000);
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [W-1:0] exp_miso(input logic [W-1:0] tx);
      return MISO_EN ? tx : '0;
   endfunction

   task automatic begin_frame();
      ss_n = 1'b0;
      wait_clk(2);
      check("busy_before_ss_latency", busy, 0);
      wait_clk(1);
      check("busy_after_ss_fall", busy, 1);
      wait_clk(2);
   endtask

   task automatic end_frame();
      wait_clk(5);
      ss_n = 1'b1;
      wait_clk(2);
      check("busy_held_after_ss_rise", busy, 1);
      wait_clk(1);
      check("busy_drop_3clk", busy, 0);
      check("miso_idle", miso, 0);
      wait_clk(5);
   endtask

   // Master side of one word: SCLK = clk/10, master samples MISO on its rise.
   task automatic xfer(input logic [W-1:0] out_b, input int nbits,
                       input logic [W-1:0] tx_next, output logic [W-1:0] in_b);
      in_b = '0;
      for (int i = 0; i < nbits; i++) begin
         if (i == W - 1) tx_data = tx_next;
         mosi = out_b[W-1-i];
         wait_clk(5);
         sclk = 1'b1;
         in_b[W-1-i] = miso;
         wait_clk(5);
         sclk = 1'b0;
      end
   endtask

   typedef struct {
      logic [W-1:0] mosi_b;
      logic [W-1:0] tx;
      int           nbits;
      int           exp_valid;
      logic [W-1:0] exp_rx;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [W-1:0] got, got1, got2, w, nxt, tx0;
      logic [W-1:0] sent[$];
      logic [W-1:0] miso_exp[$];
      int           base, nw;

      vecs[0] = '{8'hA5, 8'h00, 8, 1, 8'hA5};
      vecs[1] = '{8'hFF, 8'h3C, 8, 1, 8'hFF};
      vecs[2] = '{8'h00, 8'hFF, 8, 1, 8'h00};
      vecs[3] = '{8'h7E, 8'h81, 8, 1, 8'h7E};
      vecs[4] = '{8'hC3, 8'h55, 5, 0, 8'h7E};

      // Reset state
      wait_clk(2);
      check("reset_rx_data", rx_data, 0);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_miso", miso, 0);
      reset = 1'b0;
      wait_clk(10);

      // Idle: SCLK toggles with ss_n high
      for (int i = 0; i < 10; i++) begin
         sclk = 1'b1;
         mosi = 1'($urandom_range(0, 1));
         wait_clk(3);
         check("idle_busy", busy, 0);
         check("idle_miso", miso, 0);
         sclk = 1'b0;
         wait_clk(3);
      end
      check("idle_valid_count", valid_cnt, 0);
      check("idle_rx_data", rx_data, 0);

      // Table of single-word frames
      foreach (vecs[i]) begin
         tx_data = vecs[i].tx;
         base    = valid_cnt;
         begin_frame();
         xfer(vecs[i].mosi_b, vecs[i].nbits, vecs[i].tx, got);
         end_frame();
         check($sformatf("vec%0d_valid_pulses", i), valid_cnt - base, vecs[i].exp_valid);
         check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_rx);
         if (vecs[i].nbits == W)
            check($sformatf("vec%0d_miso_word", i), got, exp_miso(vecs[i].tx));
      end

      // Multi-word frame with tx_data changed before the 8th rise
      tx_data = 8'h0F;
      base    = valid_cnt;
      rx_log.delete();
      begin_frame();
      xfer(8'h12, W, 8'hF0, got1);
      xfer(8'h34, W, 8'hF0, got2);
      end_frame();
      check("multi_valid_pulses", valid_cnt - base, 2);
      check("multi_log_size", rx_log.size(), 2);
      check("multi_word0", (rx_log.size() > 0) ? rx_log[0] : 8'hxx, 8'h12);
      check("multi_word1", (rx_log.size() > 1) ? rx_log[1] : 8'hxx, 8'h34);
      check("multi_miso0", got1, exp_miso(8'h0F));
      check("multi_miso1", got2, exp_miso(8'hF0));

      // Abort after 5 bits, then a full word
      tx_data = 8'hAA;
      base    = valid_cnt;
      begin_frame();
      xfer(8'hC3, 5, 8'hAA, got);
      end_frame();
      check("abort_no_valid", valid_cnt - base, 0);
      check("abort_rx_held", rx_data, 8'h34);
      base = valid_cnt;
      begin_frame();
      xfer(8'h81, W, 8'hAA, got);
      end_frame();
      check("after_abort_valid", valid_cnt - base, 1);
      check("after_abort_rx", rx_data, 8'h81);
      check("after_abort_miso", got, exp_miso(8'hAA));

      // Reset mid-word after 3 bits
      tx_data = 8'hFF;
      begin_frame();
      xfer(8'h3C, 3, 8'hFF, got);
      wait_clk(2);
      check("midword_busy_before_reset", busy, 1);
      check("midword_miso_before_reset", miso, exp_miso(8'hFF) >> (W - 1));
      reset = 1'b1;
      #1;
      check("midreset_rx_data", rx_data, 0);
      check("midreset_rx_valid", rx_valid, 0);
      check("midreset_busy", busy, 0);
      check("midreset_miso", miso, 0);
      ss_n = 1'b1;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(10);
      check("post_reset_busy", busy, 0);
      base = valid_cnt;
      begin_frame();
      xfer(8'h5A, W, 8'hFF, got);
      end_frame();
      check("post_reset_valid", valid_cnt - base, 1);
      check("post_reset_rx", rx_data, 8'h5A);

      // Random multi-word frames against a word-level model
      for (int f = 0; f < 10; f++) begin
         nw  = int'($urandom_range(1, 3));
         tx0 = 8'($urandom);
         tx_data = tx0;
         sent.delete();
         miso_exp.delete();
         miso_exp.push_back(exp_miso(tx0));
         rx_log.delete();
         base = valid_cnt;
         begin_frame();
         for (int k = 0; k < nw; k++) begin
            w   = 8'($urandom);
            nxt = 8'($urandom);
            xfer(w, W, nxt, got);
            sent.push_back(w);
            miso_exp.push_back(exp_miso(nxt));
            check($sformatf("rand%0d_miso%0d", f, k), got, miso_exp[k]);
         end
         end_frame();
         check($sformatf("rand%0d_valid_pulses", f), valid_cnt - base, nw);
         for (int k = 0; k < nw; k++)
            check($sformatf("rand%0d_word%0d", f, k),
                  (rx_log.size() > k) ? rx_log[k] : 8'hxx, sent[k]);
         check($sformatf("rand%0d_rx_data", f), rx_data, sent[nw-1]);
      end

      check("no_consecutive_valid", consec_err, 0);
      check("no_valid_outside_frame", idle_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
